// File: rtl/decoder_x4_pkg.sv
// decoder_x4_pkg: shared FSM state type, default timing and counter width for decoder_x4_seq.
package decoder_x4_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;
  localparam int DEF_PULSE_LEN = 4;
  localparam int DEF_GAP_LEN   = 1;
  localparam int CNT_W         = 8;
  function automatic logic [3:0] onehot(input logic [1:0] code);
    return 4'b0001 << code;
  endfunction
endpackage

// File: rtl/code_fifo.sv
// code_fifo: 2-entry FIFO of 2-bit codes with registered occupancy count.
module code_fifo (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [1:0] din,
  output logic [1:0] head,
  output logic [1:0] count
);
  logic [1:0] mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic       do_push;
  logic       do_pop;
  assign do_push = push && (count != 2'd2);
  assign do_pop  = pop && (count != 2'd0);
  assign head    = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '{default: '0};
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end
endmodule

// File: rtl/decoder_x4_seq.sv
// decoder_x4_seq: buffers 2-bit codes and drives each as a timed one-hot pulse on x,
// with an optional zero gap between pulses.
module decoder_x4_seq
  import decoder_x4_pkg::*;
#(
  parameter int PULSE_LEN = DEF_PULSE_LEN,
  parameter int GAP_LEN   = DEF_GAP_LEN
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] z,
  input  logic       y,
  output logic       ready,
  output logic [3:0] x,
  output logic       busy,
  output logic       done
);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       x_n;
  logic             done_n;
  logic             push;
  logic             pop;
  logic [1:0]       head;
  logic [1:0]       count;
  logic             pending;
  // ready comes only from the registered count, so y never reaches ready combinationally
  assign ready   = count < 2'd2;
  assign push    = y && ready;
  assign pending = count != 2'd0;
  assign busy    = (state != IDLE) || pending;
  code_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (z),
    .head  (head),
    .count (count)
  );
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    x_n     = x;
    done_n  = 1'b0;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        x_n = 4'b0000;
        if (pending) begin
          pop     = 1'b1;
          x_n     = onehot(head);
          cnt_n   = PULSE_LOAD;
          state_n = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt != '0) cnt_n = cnt - ONE;
        else begin
          done_n = 1'b1;
          if (GAP_LEN > 0) begin
            cnt_n   = GAP_LOAD;
            x_n     = 4'b0000;
            state_n = GAP;
          end else if (pending) begin
            pop   = 1'b1;
            x_n   = onehot(head);
            cnt_n = PULSE_LOAD;
          end else begin
            x_n     = 4'b0000;
            state_n = IDLE;
          end
        end
      end
      GAP: begin
        x_n = 4'b0000;
        if (cnt != '0) cnt_n = cnt - ONE;
        else if (pending) begin
          pop     = 1'b1;
          x_n     = onehot(head);
          cnt_n   = PULSE_LOAD;
          state_n = DRIVE;
        end else state_n = IDLE;
      end
      default: begin
        x_n     = 4'b0000;
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      x     <= 4'b0000;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      x     <= x_n;
      done  <= done_n;
    end
  end
endmodule

// File: tb/tb_decoder_x4_seq.sv
// tb_decoder_x4_seq: directed self-checking bench for decoder_x4_seq (default timing and a
// PULSE_LEN=1/GAP_LEN=0 instance), with hand-computed expected values.
module tb_decoder_x4_seq;
  logic       clk;
  logic       rst_n;
  logic [1:0] z, z2;
  logic       y, y2;
  logic       ready, ready2;
  logic [3:0] x, x2;
  logic       busy, busy2;
  logic       done, done2;
  int checks = 0;
  int failures = 0;

  decoder_x4_seq dut (
    .clk(clk), .rst_n(rst_n), .z(z), .y(y),
    .ready(ready), .x(x), .busy(busy), .done(done)
  );
  decoder_x4_seq #(.PULSE_LEN(1), .GAP_LEN(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .z(z2), .y(y2),
    .ready(ready2), .x(x2), .busy(busy2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference one-hot encoder: {valid, index}
  function automatic logic [2:0] enc(input logic [3:0] v);
    case (v)
      4'b0001: return 3'b100;
      4'b0010: return 3'b101;
      4'b0100: return 3'b110;
      4'b1000: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; y = 1'b0; z = 2'd0; y2 = 1'b0; z2 = 2'd0;
    #2;
    checks++; if (x !== 4'b0000) begin failures++; $display("FAIL reset_x got=%b exp=0000", x); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (x !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL post_reset_idle x=%b busy=%b exp x=0000 busy=0", x, busy); end
  endtask

  task automatic test_single();
    y = 1'b1; z = 2'd2;
    tick();
    y = 1'b0;
    checks++; if (busy !== 1'b1 || x !== 4'b0000) begin failures++; $display("FAIL single_accept busy=%b x=%b exp busy=1 x=0000", busy, x); end
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (x !== 4'b0100 || done !== 1'b0) begin failures++; $display("FAIL single_drive cyc=%0d x=%b done=%b exp x=0100 done=0", i, x, done); end
    end
    tick();
    checks++; if (x !== 4'b0000 || done !== 1'b1) begin failures++; $display("FAIL single_end x=%b done=%b exp x=0000 done=1", x, done); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0 || x !== 4'b0000) begin failures++; $display("FAIL single_idle done=%b busy=%b x=%b exp 0 0 0000", done, busy, x); end
  endtask

  task automatic test_back_pressure();
    int feed [4] = '{3, 0, 1, 2};
    int exp_seq [20] = '{3,3,3,3,-1, 0,0,0,0,-1, 1,1,1,1,-1, 2,2,2,2,-1};
    int fi = 0;
    int dones = 0;
    logic rdy;
    logic [3:0] ex;
    for (int c = 0; c <= 20; c++) begin
      if (fi < 4) begin y = 1'b1; z = 2'(feed[fi]); end
      else y = 1'b0;
      rdy = ready;
      tick();
      if (y && rdy) fi++;
      if (done) dones++;
      if (c == 2) begin
        checks++; if (ready !== 1'b0 || fi != 3) begin failures++; $display("FAIL bp_stall ready=%b accepted=%0d exp ready=0 accepted=3", ready, fi); end
      end
      if (c >= 1) begin
        ex = (exp_seq[c-1] < 0) ? 4'b0000 : (4'b0001 << exp_seq[c-1]);
        checks++; if (x !== ex) begin failures++; $display("FAIL bp_x cyc=%0d got=%b exp=%b", c, x, ex); end
        checks++;
        if (enc(x) !== ((exp_seq[c-1] < 0) ? 3'b000 : {1'b1, 2'(exp_seq[c-1])})) begin
          failures++; $display("FAIL bp_roundtrip cyc=%0d enc=%b x=%b", c, enc(x), x);
        end
      end
    end
    y = 1'b0;
    checks++; if (dones != 4) begin failures++; $display("FAIL bp_done_count got=%0d exp=4", dones); end
    checks++; if (fi != 4) begin failures++; $display("FAIL bp_accepted got=%0d exp=4", fi); end
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_idle busy=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    y2 = 1'b1; z2 = 2'd0;
    tick();
    z2 = 2'd1;
    tick();
    y2 = 1'b0;
    checks++; if (x2 !== 4'b0001 || done2 !== 1'b0) begin failures++; $display("FAIL b2b_first x=%b done=%b exp 0001 0", x2, done2); end
    tick();
    checks++; if (x2 !== 4'b0010 || done2 !== 1'b1) begin failures++; $display("FAIL b2b_second x=%b done=%b exp 0010 1", x2, done2); end
    tick();
    checks++; if (x2 !== 4'b0000 || done2 !== 1'b1) begin failures++; $display("FAIL b2b_end x=%b done=%b exp 0000 1", x2, done2); end
    tick();
    checks++; if (done2 !== 1'b0 || busy2 !== 1'b0) begin failures++; $display("FAIL b2b_idle done=%b busy=%b exp 0 0", done2, busy2); end
  endtask

  task automatic test_reset_mid_drive();
    y = 1'b1; z = 2'd1;
    tick();
    z = 2'd2;
    tick();
    y = 1'b0;
    checks++; if (x !== 4'b0010 || busy !== 1'b1) begin failures++; $display("FAIL mid_pre x=%b busy=%b exp 0010 1", x, busy); end
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (x !== 4'b0000 || busy !== 1'b0 || ready !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL mid_reset x=%b busy=%b ready=%b done=%b exp 0000 0 1 0", x, busy, ready, done);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (x !== 4'b0000 || done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mid_after cyc=%0d x=%b done=%b busy=%b exp 0000 0 0", i, x, done, busy); end
    end
    y = 1'b1; z = 2'd0;
    tick();
    y = 1'b0;
    tick();
    checks++; if (x !== 4'b0001) begin failures++; $display("FAIL mid_restart x=%b exp=0001", x); end
    for (int i = 0; i < 6; i++) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_pressure();
    test_back_to_back();
    test_reset_mid_drive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
